sram_device_emulator: RTL
=========================

Name: sram_device_emulator

Overview:
- Clocked, BRAM-backed emulator of the Pocket's external async 128K x 16 SRAM. It sits on the device side of the SRAM pin bus and replaces the physical chip in simulation and in on-FPGA loopback builds.
- It decodes the active-low OE/WE/UB/LB strobes, enforces a programmable read access time, and commits writes on the WE rising edge.
- It flags protocol violations so the controller's wait-cycle tuning can be verified.

Parameters:
- MEM_ADDR_BITS, 14: implemented depth is 2^MEM_ADDR_BITS halfwords. Higher address bits are ignored, so addresses alias.
- READ_LATENCY, 4: clocks from a stable read request to valid data. Minimum 2, maximum 15.
- POISON, 16'hDEAD: value driven while read data is not yet valid, and on any disabled byte lane.

Ports:
- clk  in  1  single clock, same domain as the controller
- reset  in  1  synchronous, active-high
- sram_a  in  17  halfword address from host
- sram_dq_in  in  16  data driven by host
- sram_dq_host_oe  in  1  host is driving the bus
- sram_oe_n  in  1  output enable, active low
- sram_we_n  in  1  write enable, active low
- sram_ub_n  in  1  upper byte enable, active low
- sram_lb_n  in  1  lower byte enable, active low
- sram_dq_out  out  16  data driven by emulator
- sram_dq_oe  out  1  emulator drives bus
- rd_valid  out  1  sram_dq_out holds real memory data
- err_flags  out  4  sticky: [0] bus contention, [1] OE and WE both low, [2] address change during WE low, [3] read sampled early (reserved, tied 0)
- err_count  out  8  total violation events, saturating at 255

Behaviour:
- Reset values: sram_dq_out=POISON, sram_dq_oe=0, rd_valid=0, err_flags=0, err_count=0, read FSM in R_IDLE, write latches cleared. Memory contents are not cleared.
- Read request (rreq): oe_n=0 AND we_n=1 AND (ub_n=0 OR lb_n=0).
- Read FSM, R_IDLE -> R_ACCESS:
  - Transition when rreq is asserted.
  - On entry, the counter loads READ_LATENCY-1.
  - The address and {ub_n,lb_n} are captured.
- R_ACCESS:
  - The counter decrements each clock.
  - If the address or byte enables differ from the captured values, return to R_ACCESS with the counter reloaded (restart).
  - At counter 0, go to R_VALID.
  - If rreq deasserts, go to R_IDLE.
- R_VALID:
  - rd_valid=1.
  - sram_dq_out = mem[a], with a lane set to POISON's matching byte when its enable is high.
  - An address or enable change returns to R_ACCESS (restart).
  - rreq deasserting returns to R_IDLE.
- Memory read is a 1-cycle synchronous BRAM read, issued on the captured address. That is why READ_LATENCY must be at least 2.
- sram_dq_oe is registered as rreq, so it asserts 1 clock after rreq and deasserts 1 clock after rreq drops. Outside R_VALID, sram_dq_out=POISON and rd_valid=0.
- Write:
  - Every clock with we_n=0, latch a, dq_in, ub_n and lb_n into w_* registers.
  - Commit on the registered rising edge (we_q=0, we_n=1), using w_* from the last WE-low cycle.
  - Lower byte is written when w_lb_n=0; upper byte is written when w_ub_n=0. Strobes deasserting in the same clock as WE rises must not cancel the write.
- A zero-length WE pulse, meaning both enables high for the whole pulse, writes nothing.
- Write/read ordering: a read starting the clock after a commit must return the new data. Provide a bypass, or rely on the latency of 2 or more.
- Violations (each sets its flag and increments err_count by 1 per clock it holds, saturating):
  - [0] sram_dq_host_oe=1 while sram_dq_oe=1.
  - [1] oe_n=0 and we_n=0. Write wins; no read is started.
  - [2] sram_a changes while we_n stays 0.
- A reset asserted mid-write discards the pending commit. A reset mid-read returns the FSM to R_IDLE.

Test Plan:
- Reset, then a write pulse: a=17'h00010, dq=16'h1234, ub=lb=0, we_n low 5 clocks, with strobes raised together with we_n. Then read the same address with oe_n held low 6 clocks. Required: rd_valid rises at clock 4 after oe_n falls (READ_LATENCY=4), sram_dq_out=16'h1234, and it is POISON before that.
- Byte lanes: write 16'hAAAA with lb only to a=5, then read with ub only. Required: sram_dq_out={8'h??_prev_upper, 8'hAD}. With the memory pre-written as 16'h0000, the upper byte is 8'h00 and the lower lane is POISON's byte 8'hAD.
- Early sample: the host drops oe_n for only 2 clocks. Required: rd_valid never asserts and the emulator drives only 16'hDEAD.
- Address change mid-read: a changes from 3 to 4 at clock 2 of the access. Required: the counter restarts, and valid data for a=4 appears 4 clocks after the change.
- Violations: we_n=0 with oe_n=0 for 3 clocks, then dq_host_oe=1 during a driven read for 1 clock. Required: err_flags=4'b0011 and err_count=4. Then 300 contention clocks give err_count=255.
- Aliasing: write 16'hBEEF to a=17'h04007 with MEM_ADDR_BITS=14, then read a=17'h00007. Required: 16'hBEEF.

Source files
------------

// File: rtl/sram_device_emulator.sv
// Clocked BRAM model of a 128K x 16 async SRAM: strobe decode, programmable read access time,
// write commit on WE rising edge, and sticky protocol-violation flags with a saturating event count.
`timescale 1ns/1ps
module sram_device_emulator #(
  parameter int          MEM_ADDR_BITS = 14,
  parameter int          READ_LATENCY  = 4,
  parameter logic [15:0] POISON        = 16'hDEAD
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [16:0] sram_a_i,
  input  logic [15:0] sram_dq_in_i,
  input  logic        sram_dq_host_oe_i,
  input  logic        sram_oe_n_i,
  input  logic        sram_we_n_i,
  input  logic        sram_ub_n_i,
  input  logic        sram_lb_n_i,
  output logic [15:0] sram_dq_out_o,
  output logic        sram_dq_oe_o,
  output logic        rd_valid_o,
  output logic [3:0]  err_flags_o,
  output logic [7:0]  err_count_o
);

  localparam int          DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [3:0]  LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_VALID} rstate_e;

  rstate_e     state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] cap_a_q, cap_a_d;
  logic [1:0]  cap_be_q, cap_be_d;
  logic        dq_oe_q;
  logic [15:0] rdata_q;

  logic        we_q;
  logic [16:0] w_a_q, w_a_d;
  logic [15:0] w_dq_q, w_dq_d;
  logic        w_ub_n_q, w_ub_n_d, w_lb_n_q, w_lb_n_d;

  logic [3:0]  err_flags_q, err_flags_d;
  logic [7:0]  err_count_q, err_count_d;

  logic [15:0] mem [DEPTH];

  logic rreq, req_chg, commit;
  logic v0, v1, v2;
  logic [1:0] n_viol;
  logic [8:0] cnt_sum;

  assign rreq    = !sram_oe_n_i && sram_we_n_i && (!sram_ub_n_i || !sram_lb_n_i);
  assign req_chg = (sram_a_i != cap_a_q) || ({sram_ub_n_i, sram_lb_n_i} != cap_be_q);
  assign commit  = !we_q && sram_we_n_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= R_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE:   if (rreq) state_d = R_ACCESS;
      R_ACCESS: begin
        if (!rreq)            state_d = R_IDLE;
        else if (req_chg)     state_d = R_ACCESS;
        else if (cnt_q <= 4'd1) state_d = R_VALID;
      end
      R_VALID: begin
        if (!rreq)        state_d = R_IDLE;
        else if (req_chg) state_d = R_ACCESS;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_valid_o    = (state_q == R_VALID);
    sram_dq_out_o = POISON;
    if (state_q == R_VALID) begin
      sram_dq_out_o[15:8] = cap_be_q[1] ? POISON[15:8] : rdata_q[15:8];
      sram_dq_out_o[7:0]  = cap_be_q[0] ? POISON[7:0]  : rdata_q[7:0];
    end
  end

  // Any change of request while busy reloads the access timer, same as a fresh request.
  always_comb begin
    cnt_d    = cnt_q;
    cap_a_d  = cap_a_q;
    cap_be_d = cap_be_q;
    if (rreq && (state_q == R_IDLE || req_chg)) begin
      cnt_d    = LOAD;
      cap_a_d  = sram_a_i;
      cap_be_d = {sram_ub_n_i, sram_lb_n_i};
    end else if (state_q == R_ACCESS && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_comb begin
    w_a_d    = w_a_q;
    w_dq_d   = w_dq_q;
    w_ub_n_d = w_ub_n_q;
    w_lb_n_d = w_lb_n_q;
    if (!sram_we_n_i) begin
      w_a_d    = sram_a_i;
      w_dq_d   = sram_dq_in_i;
      w_ub_n_d = sram_ub_n_i;
      w_lb_n_d = sram_lb_n_i;
    end
  end

  assign v0      = sram_dq_host_oe_i && dq_oe_q;
  assign v1      = !sram_oe_n_i && !sram_we_n_i;
  assign v2      = !sram_we_n_i && !we_q && (sram_a_i != w_a_q);
  assign n_viol  = {1'b0, v0} + {1'b0, v1} + {1'b0, v2};
  assign cnt_sum = {1'b0, err_count_q} + {7'd0, n_viol};

  always_comb begin
    err_flags_d = err_flags_q | {1'b0, v2, v1, v0};
    err_count_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= 4'd0;
      cap_a_q     <= 17'd0;
      cap_be_q    <= 2'b11;
      dq_oe_q     <= 1'b0;
      we_q        <= 1'b1;
      w_a_q       <= 17'd0;
      w_dq_q      <= 16'd0;
      w_ub_n_q    <= 1'b1;
      w_lb_n_q    <= 1'b1;
      err_flags_q <= 4'd0;
      err_count_q <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      cap_a_q     <= cap_a_d;
      cap_be_q    <= cap_be_d;
      dq_oe_q     <= rreq;
      we_q        <= sram_we_n_i;
      w_a_q       <= w_a_d;
      w_dq_q      <= w_dq_d;
      w_ub_n_q    <= w_ub_n_d;
      w_lb_n_q    <= w_lb_n_d;
      err_flags_q <= err_flags_d;
      err_count_q <= err_count_d;
    end
  end

  // Memory array is never reset; a reset coinciding with WE rising drops that commit.
  always_ff @(posedge clk_i) begin
    if (commit && !reset_i) begin
      if (!w_lb_n_q) mem[w_a_q[MEM_ADDR_BITS-1:0]][7:0]  <= w_dq_q[7:0];
      if (!w_ub_n_q) mem[w_a_q[MEM_ADDR_BITS-1:0]][15:8] <= w_dq_q[15:8];
    end
    rdata_q <= mem[cap_a_q[MEM_ADDR_BITS-1:0]];
  end

  assign sram_dq_oe_o = dq_oe_q;
  assign err_flags_o  = err_flags_q;
  assign err_count_o  = err_count_q;

endmodule
